// File: rtl/dvp_pixel_tx.sv
// DVP camera emulator: pulls 12-bit RGB444 pixels from a valid/ready source and
// replays them as OV7670-style vsync/href/8-bit byte pairs on the pixel clock.
module dvp_pixel_tx #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int VSYNC_LEN = 3,
   parameter int VBP       = 17,
   parameter int HBLANK    = 5,
   parameter int VFP       = 10
) (
   input  logic        i_pclk,
   input  logic        i_rstn,
   input  logic        i_en,
   input  logic        i_pix_valid,
   input  logic [11:0] i_pix_data,
   output logic        o_pix_ready,
   output logic        o_vsync,
   output logic        o_href,
   output logic [7:0]  o_data,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_underflow
);

   localparam int COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int ROW_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int PH_A   = (VSYNC_LEN > VBP) ? VSYNC_LEN : VBP;
   localparam int PH_B   = (HBLANK > VFP) ? HBLANK : VFP;
   localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [COL_W-1:0] COL_LAST    = COL_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(V_ACTIVE - 1);
   localparam logic [PH_W-1:0]  VSYNC_LAST  = PH_W'(VSYNC_LEN - 1);
   localparam logic [PH_W-1:0]  VBP_LAST    = PH_W'(VBP - 1);
   localparam logic [PH_W-1:0]  HBLANK_LAST = PH_W'(HBLANK - 1);
   localparam logic [PH_W-1:0]  VFP_LAST    = PH_W'(VFP - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBP, S_ACT_HI, S_ACT_LO, S_HBLANK, S_VFP
   } state_t;

   state_t           state_reg, state_next;
   logic [PH_W-1:0]  phase_reg, phase_next;
   logic [COL_W-1:0] col_reg, col_next;
   logic [ROW_W-1:0] row_reg, row_next;
   logic [11:0]      pix_reg;
   logic             underflow_reg;

   always_ff @(posedge i_pclk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_reg <= S_IDLE;
         phase_reg <= '0;
         col_reg   <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      case (state_reg)
         S_IDLE: begin
            if (i_en) begin
               state_next = S_VSYNC;
               phase_next = '0;
            end
         end
         S_VSYNC: begin
            if (phase_reg == VSYNC_LAST) begin
               state_next = S_VBP;
               phase_next = '0;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         S_VBP: begin
            if (phase_reg == VBP_LAST) begin
               state_next = S_ACT_HI;
               phase_next = '0;
               col_next   = '0;
               row_next   = '0;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         S_ACT_HI: state_next = S_ACT_LO;
         S_ACT_LO: begin
            if (col_reg == COL_LAST) begin
               state_next = S_HBLANK;
               col_next   = '0;
               phase_next = '0;
            end else begin
               state_next = S_ACT_HI;
               col_next   = col_reg + 1'b1;
            end
         end
         S_HBLANK: begin
            if (phase_reg == HBLANK_LAST) begin
               phase_next = '0;
               if (row_reg != ROW_LAST) begin
                  state_next = S_ACT_HI;
                  row_next   = row_reg + 1'b1;
               end else begin
                  state_next = S_VFP;
                  row_next   = '0;
               end
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         S_VFP: begin
            if (phase_reg == VFP_LAST) begin
               phase_next = '0;
               state_next = i_en ? S_VSYNC : S_IDLE;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs decode only registered state, so nothing from the inputs reaches a pin combinationally.
   always_comb begin
      o_vsync     = 1'b0;
      o_href      = 1'b0;
      o_data      = 8'h00;
      o_sof       = 1'b0;
      o_eof       = 1'b0;
      o_pix_ready = 1'b0;
      case (state_reg)
         S_VSYNC: begin
            o_vsync = 1'b1;
            o_sof   = (phase_reg == '0);
         end
         S_VBP:    o_pix_ready = (phase_reg == VBP_LAST);
         S_ACT_HI: begin
            o_href = 1'b1;
            o_data = {4'hF, pix_reg[11:8]};
         end
         S_ACT_LO: begin
            o_href      = 1'b1;
            o_data      = pix_reg[7:0];
            o_pix_ready = (col_reg != COL_LAST);
         end
         S_HBLANK: begin
            o_eof       = (phase_reg == '0) && (row_reg == ROW_LAST);
            o_pix_ready = (phase_reg == HBLANK_LAST) && (row_reg != ROW_LAST);
         end
         default: ;
      endcase
   end

   // A missing pixel still consumes its slot as black; timing never stretches.
   always_ff @(posedge i_pclk or negedge i_rstn) begin
      if (!i_rstn) begin
         pix_reg       <= '0;
         underflow_reg <= 1'b0;
      end else if (o_pix_ready) begin
         if (i_pix_valid) begin
            pix_reg <= i_pix_data;
         end else begin
            pix_reg       <= '0;
            underflow_reg <= 1'b1;
         end
      end
   end

   assign o_underflow = underflow_reg;

endmodule
